// File: rtl/simple_bus_pkg.sv
// -----------------------------------------------------------------------------
// simple_bus_pkg
// Shared types and constants for the SimpleBus multi-master front end.
//   ADDR_W      : requester-side address width (16)
//   BUS_W       : SimpleBus address/data lane width (8)
//   addr_t      : 16-bit requester address
//   byte_t      : 8-bit bus byte
//   arb_state_t : arbiter sequencing states
// -----------------------------------------------------------------------------
package simple_bus_pkg;

    localparam int ADDR_W = 16;
    localparam int BUS_W  = 8;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [BUS_W-1:0]  byte_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR_HI = 3'd1,
        ST_ADDR_LO = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_WR_DATA = 3'd4
    } arb_state_t;

endpackage

// File: rtl/simple_bus_rr_pick.sv
// -----------------------------------------------------------------------------
// simple_bus_rr_pick
// Combinational round-robin picker. Searches req upward starting at ptr,
// wrapping around, and reports the first set bit.
// Ports:
//   req        in  NUM_REQ : candidate requests
//   ptr        in  IDX_W   : highest-priority index
//   win_onehot out NUM_REQ : one-hot winner (all zero when no request)
//   win_idx    out IDX_W   : winner index (0 when no request)
//   any        out 1       : at least one request present
// -----------------------------------------------------------------------------
module simple_bus_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win_onehot,
    output logic [IDX_W-1:0]   win_idx,
    output logic               any
);

    logic found;

    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            int cand;
            cand = int'(ptr) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && req[IDX_W'(cand)]) begin
                found   = 1'b1;
                win_idx = IDX_W'(cand);
            end
        end
    end

    assign any = found;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
        assign win_onehot[gi] = found && (win_idx == IDX_W'(gi));
    end

endmodule

// File: rtl/simple_bus_arbiter.sv
// -----------------------------------------------------------------------------
// simple_bus_arbiter
// Round-robin multi-master front end for the SimpleBus. Grants one requester
// at a time and sequences its transfer as the ProcessorPort master:
// high address byte with start, low address byte with read, then either a
// one-cycle write data phase or a wait for the memory's dataValid.
//
// Optional feature macro: SIMPLE_BUS_ARB_TIMEOUT_EN
//   defined   : read wait is bounded to RD_TIMEOUT cycles, then err pulses.
//   undefined : read wait is unbounded and err stays 0.
//
// Ports:
//   clock, resetN      : clock, asynchronous active-low reset
//   req/rd             : per-requester request level and direction (1 = read)
//   addr/wdata         : packed per-requester address (16b) and write data (8b)
//   gnt                : one-hot grant, held for the whole transfer
//   done/err           : one-cycle completion / timeout pulse to the winner
//   rdata              : last read result, held until the next read completes
//   start/address/read : bus master outputs (address tri-stated when idle)
//   data/dataValid     : shared bus lines, driven only in the write data phase
// -----------------------------------------------------------------------------
module simple_bus_arbiter
    import simple_bus_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int RD_TIMEOUT = 12
) (
    input  logic                      clock,
    input  logic                      resetN,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        rd,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*BUS_W-1:0]  wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic [NUM_REQ-1:0]        err,
    output byte_t                     rdata,
    output logic                      start,
    output wire  [BUS_W-1:0]          address,
    output logic                      read,
    inout  wire  [BUS_W-1:0]          data,
    inout  wire                       dataValid
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("simple_bus_arbiter: NUM_REQ must be 2..8");
    end
    if (RD_TIMEOUT < 1 || RD_TIMEOUT > 255) begin : g_bad_rd_timeout
        $error("simple_bus_arbiter: RD_TIMEOUT must fit the 8-bit watchdog");
    end

    arb_state_t         state_reg;
    logic [IDX_W-1:0]   ptr_reg;
    logic [IDX_W-1:0]   win_idx_reg;
    logic               rd_lat_reg;
    addr_t              addr_lat_reg;
    byte_t              wdata_lat_reg;
    logic [NUM_REQ-1:0] gnt_reg;
    logic [NUM_REQ-1:0] done_reg;
    logic [NUM_REQ-1:0] err_reg;
    byte_t              rdata_reg;
    logic               start_reg;
    logic               read_reg;
    byte_t              addr_out_reg;
    logic               addr_oe_reg;
    byte_t              data_out_reg;
    logic               data_oe_reg;
`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
    logic [7:0]         rd_timer_reg;
`endif

    logic [NUM_REQ-1:0] pick_req;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [IDX_W-1:0]   ptr_next;

    // A read completes while the FSM is already back in IDLE, and the
    // requester only sees done at the end of that cycle, so its req is still
    // high. Masking the requester being answered stops an immediate re-grant.
    assign pick_req = req & ~done_reg & ~err_reg;

    simple_bus_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req        (pick_req),
        .ptr        (ptr_reg),
        .win_onehot (pick_onehot),
        .win_idx    (pick_idx),
        .any        (pick_any)
    );

    // The completing requester drops to lowest priority.
    assign ptr_next = (win_idx_reg == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx_reg + 1'b1;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_reg     <= ST_IDLE;
            ptr_reg       <= '0;
            win_idx_reg   <= '0;
            rd_lat_reg    <= 1'b0;
            addr_lat_reg  <= '0;
            wdata_lat_reg <= '0;
            gnt_reg       <= '0;
            done_reg      <= '0;
            err_reg       <= '0;
            rdata_reg     <= '0;
            start_reg     <= 1'b0;
            read_reg      <= 1'b0;
            addr_out_reg  <= '0;
            addr_oe_reg   <= 1'b0;
            data_out_reg  <= '0;
            data_oe_reg   <= 1'b0;
`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
            rd_timer_reg  <= '0;
`endif
        end else begin
            // Pulse outputs default low every cycle.
            done_reg  <= '0;
            err_reg   <= '0;
            start_reg <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (pick_any) begin
                        gnt_reg       <= pick_onehot;
                        win_idx_reg   <= pick_idx;
                        rd_lat_reg    <= rd[pick_idx];
                        addr_lat_reg  <= addr[pick_idx*ADDR_W +: ADDR_W];
                        wdata_lat_reg <= wdata[pick_idx*BUS_W +: BUS_W];
                        // High byte goes straight from the input so it is on
                        // the bus in the very first ADDR_HI cycle.
                        start_reg     <= 1'b1;
                        addr_out_reg  <= addr[pick_idx*ADDR_W + BUS_W +: BUS_W];
                        addr_oe_reg   <= 1'b1;
                        state_reg     <= ST_ADDR_HI;
                    end
                end

                ST_ADDR_HI: begin
                    addr_out_reg <= addr_lat_reg[BUS_W-1:0];
                    read_reg     <= rd_lat_reg;
`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
                    rd_timer_reg <= '0;
`endif
                    state_reg    <= ST_ADDR_LO;
                end

                ST_ADDR_LO: begin
                    read_reg    <= 1'b0;
                    addr_oe_reg <= 1'b0;
                    if (rd_lat_reg) begin
                        state_reg <= ST_RD_WAIT;
                    end else begin
                        data_out_reg <= wdata_lat_reg;
                        data_oe_reg  <= 1'b1;
                        done_reg     <= gnt_reg;
                        state_reg    <= ST_WR_DATA;
                    end
                end

                ST_RD_WAIT: begin
                    if (dataValid) begin
                        rdata_reg <= data;
                        done_reg  <= gnt_reg;
                        gnt_reg   <= '0;
                        ptr_reg   <= ptr_next;
                        state_reg <= ST_IDLE;
                    end
`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
                    else if (rd_timer_reg == 8'(RD_TIMEOUT - 1)) begin
                        err_reg   <= gnt_reg;
                        gnt_reg   <= '0;
                        ptr_reg   <= ptr_next;
                        state_reg <= ST_IDLE;
                    end else begin
                        rd_timer_reg <= rd_timer_reg + 8'd1;
                    end
`endif
                end

                ST_WR_DATA: begin
                    data_oe_reg <= 1'b0;
                    gnt_reg     <= '0;
                    ptr_reg     <= ptr_next;
                    state_reg   <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt   = gnt_reg;
    assign done  = done_reg;
    assign err   = err_reg;
    assign rdata = rdata_reg;
    assign start = start_reg;
    assign read  = read_reg;

    assign address   = addr_oe_reg ? addr_out_reg : {BUS_W{1'bz}};
    assign data      = data_oe_reg ? data_out_reg : {BUS_W{1'bz}};
    assign dataValid = data_oe_reg ? 1'b1 : 1'bz;

endmodule
